// File: rtl/bus_driver.sv
// rtl/bus_driver.sv - round-robin shared-bus source arbiter and registered bus driver
//
// Grants one of N_SRC requesting sources at a time, round-robin. The winner's
// byte is captured once at grant time and held on the bus until the sink acks.
// Optional feature macro: BUS_TIMEOUT_EN abandons a transfer after TIMEOUT
// DRIVE cycles without ack and pulses timeout_err for one cycle.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   req          per-source drive request (level)
//   src_data     source i data at [i*WIDTH +: WIDTH]
//   bus_ack      sink has loaded the bus value this cycle
//   gnt          one-hot grant (registered)
//   bus          registered bus value
//   bus_valid    bus holds a granted value
//   busy         high in DRIVE state
//   timeout_err  one-cycle pulse on abandoned transfer (0 without BUS_TIMEOUT_EN)
module bus_driver #(
  parameter int N_SRC   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic                   bus_ack,
  output logic [N_SRC-1:0]       gnt,
  output logic [WIDTH-1:0]       bus,
  output logic                   bus_valid,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic          found;

  // Scan last+1, last+2, ... (mod N_SRC); the first requester found wins.
  always_comb begin : p_arb
    int            idx;
    logic [IW-1:0] cand;
    idx   = 0;
    cand  = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx  = (int'(last) + k) % N_SRC;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      bus       <= '0;
      bus_valid <= 1'b0;
      busy      <= 1'b0;
      last      <= IW'(N_SRC - 1);
`ifdef BUS_TIMEOUT_EN
      tcnt        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef BUS_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // bus keeps its last value while idle; only the qualifier drops
          if (found) begin
            state     <= DRIVE;
            gnt       <= {{(N_SRC-1){1'b0}}, 1'b1} << win;
            bus       <= src_data[win*WIDTH +: WIDTH];
            bus_valid <= 1'b1;
            busy      <= 1'b1;
            last      <= win;
`ifdef BUS_TIMEOUT_EN
            tcnt      <= '0;
`endif
          end
        end
        DRIVE: begin
          // req and src_data are ignored here: the transfer runs to ack
          if (bus_ack) begin
            state     <= IDLE;
            gnt       <= '0;
            bus_valid <= 1'b0;
            busy      <= 1'b0;
          end
`ifdef BUS_TIMEOUT_EN
          // tcnt counts completed unacked DRIVE cycles; this is the TIMEOUT-th
          else if (tcnt == CW'(TIMEOUT - 1)) begin
            state       <= IDLE;
            gnt         <= '0;
            bus_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
